// File: rtl/cu_edge_data_write_pack_control_pkg.sv
// Shared CU types for the edge-data write packing path: element/line structs,
// cacheline geometry and the pack controller state encoding.
package CU_PKG;

  localparam int VERTEX_SIZE_BITS            = 32;
  localparam int DATA_SIZE_WRITE_BITS        = 32;
  localparam int CACHELINE_SIZE_BITS         = 1024;
  localparam int CACHELINE_DATA_WRITE_NUM    = CACHELINE_SIZE_BITS / DATA_SIZE_WRITE_BITS;
  localparam int CACHELINE_DATA_WRITE_NUM_HF = CACHELINE_DATA_WRITE_NUM / 2;
  localparam int CACHELINE_WRITE_OFFSET_BITS = $clog2(CACHELINE_DATA_WRITE_NUM);
  localparam int CACHELINE_WRITE_TAG_BITS    = VERTEX_SIZE_BITS - CACHELINE_WRITE_OFFSET_BITS;
  localparam int CU_ID_BITS                  = 8;

  typedef struct packed {
    logic [VERTEX_SIZE_BITS-1:0]     id;
    logic [DATA_SIZE_WRITE_BITS-1:0] data;
  } EdgeDataWritePayload;

  typedef struct packed {
    logic                valid;
    EdgeDataWritePayload payload;
  } EdgeDataWrite;

  typedef struct packed {
    logic [CU_ID_BITS-1:0]                  cu_id_x;
    logic [CU_ID_BITS-1:0]                  cu_id_y;
    logic [VERTEX_SIZE_BITS-1:0]            address_offset;
    logic [CACHELINE_WRITE_OFFSET_BITS-1:0] cacheline_offset;
  } CommandBufferLine;

  // Element k of a half sits at data[(HF-1-k)*DW +: DW], MSB-first like the masks.
  typedef struct packed {
    logic                                                        valid;
    CommandBufferLine                                            cmd;
    logic [CACHELINE_DATA_WRITE_NUM_HF*DATA_SIZE_WRITE_BITS-1:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic alfull;
    logic full;
    logic empty;
  } BufferStatus;

  typedef enum logic [1:0] {IDLE, FILL, EMIT, HOLD} edge_write_pack_state;

endpackage

// File: rtl/cu_cacheline_merge_buffer.sv
// One-cacheline merge buffer: per-slot data, per-slot valid mask and line tag.
// A write in the same cycle as a clear wins for its slot, so a new line can open on the emit cycle.
module cu_cacheline_merge_buffer
  import CU_PKG::*;
(
  input  logic                                                        clock,
  input  logic                                                        rstn,
  input  logic                                                        clear_i,
  input  logic                                                        wr_en_i,
  input  logic                                                        wr_open_i,
  input  logic [CACHELINE_WRITE_OFFSET_BITS-1:0]                      wr_offset_i,
  input  logic [CACHELINE_WRITE_TAG_BITS-1:0]                         wr_tag_i,
  input  logic [DATA_SIZE_WRITE_BITS-1:0]                             wr_data_i,
  output logic [CACHELINE_DATA_WRITE_NUM-1:0][DATA_SIZE_WRITE_BITS-1:0] data_o,
  output logic [CACHELINE_DATA_WRITE_NUM-1:0]                         mask_o,
  output logic [CACHELINE_WRITE_TAG_BITS-1:0]                         tag_o
);

  localparam int NUM = CACHELINE_DATA_WRITE_NUM;
  localparam int OB  = CACHELINE_WRITE_OFFSET_BITS;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      data_o <= '0;
      mask_o <= '0;
    end else begin
      for (int k = 0; k < NUM; k++) begin
        if (wr_en_i && (wr_offset_i == OB'(k))) begin
          data_o[k] <= wr_data_i;
          mask_o[k] <= 1'b1;
        end else if (clear_i) begin
          data_o[k] <= '0;
          mask_o[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn)                     tag_o <= '0;
    else if (wr_en_i && wr_open_i) tag_o <= wr_tag_i;
    else if (clear_i)              tag_o <= '0;
  end

endmodule

// File: rtl/cu_edge_data_write_pack_control.sv
// Packs single-element edge-data writes into cachelines and emits each line as two
// masked half-line write requests. The input register doubles as the one-entry pending slot.
module cu_edge_data_write_pack_control
  import CU_PKG::*;
#(
  parameter int CU_ID_X = 1,
  parameter int CU_ID_Y = 1
) (
  input  logic                                   clock,
  input  logic                                   rstn,
  input  logic                                   enabled_in,
  input  EdgeDataWrite                           edge_data_write_in,
  output logic                                   edge_data_write_ready_out,
  input  logic                                   flush_in,
  input  BufferStatus                            write_buffer_status_in,
  output ReadWriteDataLine                       write_data_0_out,
  output ReadWriteDataLine                       write_data_1_out,
  output logic [CACHELINE_DATA_WRITE_NUM_HF-1:0] write_mask_0_out,
  output logic [CACHELINE_DATA_WRITE_NUM_HF-1:0] write_mask_1_out,
  output logic                                   flush_done_out
);

  localparam int NUM = CACHELINE_DATA_WRITE_NUM;
  localparam int HF  = CACHELINE_DATA_WRITE_NUM_HF;
  localparam int DW  = DATA_SIZE_WRITE_BITS;
  localparam int OB  = CACHELINE_WRITE_OFFSET_BITS;
  localparam int TB  = CACHELINE_WRITE_TAG_BITS;

  logic                 enabled_q, alfull_q;
  EdgeDataWrite         in_q, in_d;
  edge_write_pack_state state_q, state_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 flush_src_q, flush_src_d;
  ReadWriteDataLine     wd0_q, wd0_d, wd1_q, wd1_d;
  logic [HF-1:0]        m0_q, m0_d, m1_q, m1_d;
  logic                 done_q, done_d;

  logic                     buf_clear, buf_wr, buf_open;
  logic [NUM-1:0][DW-1:0]   buf_data;
  logic [NUM-1:0]           buf_mask;
  logic [TB-1:0]            buf_tag;

  logic          alfull, flush_req, in_take, do_emit, pending_valid, line_full_next;
  logic [OB-1:0] in_off;
  logic [TB-1:0] in_tag;
  logic [NUM-1:0] in_onehot;

  // Only alfull is consumed from the status bundle.
  logic unused_status;
  assign unused_status = ^{write_buffer_status_in.full, write_buffer_status_in.empty};

  assign alfull    = write_buffer_status_in.alfull;
  assign flush_req = flush_in | flush_pend_q;
  assign in_off    = in_q.payload.id[OB-1:0];
  assign in_tag    = in_q.payload.id[VERTEX_SIZE_BITS-1:OB];
  assign in_onehot = {{(NUM-1){1'b0}}, 1'b1} << in_off;
  assign line_full_next = in_q.valid && (&(buf_mask | in_onehot));

  // The latched element cannot merge this cycle: it belongs to another line or an emit is in flight.
  assign pending_valid = in_q.valid &&
                         ((state_q == EMIT) || (state_q == HOLD) ||
                          ((state_q == FILL) && (in_tag != buf_tag)));

  assign edge_data_write_ready_out = enabled_q && ((state_q == IDLE) || (state_q == FILL)) &&
                                     !pending_valid && !alfull_q;

  cu_cacheline_merge_buffer u_buf (
    .clock       (clock),
    .rstn        (rstn),
    .clear_i     (buf_clear),
    .wr_en_i     (buf_wr),
    .wr_open_i   (buf_open),
    .wr_offset_i (in_off),
    .wr_tag_i    (in_tag),
    .wr_data_i   (in_q.payload.data),
    .data_o      (buf_data),
    .mask_o      (buf_mask),
    .tag_o       (buf_tag)
  );

  always_comb begin
    in_d = in_q;
    if (in_take) in_d.valid = 1'b0;
    if (edge_data_write_in.valid && edge_data_write_ready_out) in_d = edge_data_write_in;
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    flush_src_d  = flush_src_q;
    in_take      = 1'b0;
    buf_wr       = 1'b0;
    buf_open     = 1'b0;
    buf_clear    = 1'b0;
    do_emit      = 1'b0;
    done_d       = 1'b0;
    if (enabled_q) begin
      case (state_q)
        IDLE: begin
          flush_pend_d = 1'b0;
          if (in_q.valid) begin
            in_take  = 1'b1;
            buf_wr   = 1'b1;
            buf_open = 1'b1;
            if (flush_req) begin
              state_d     = EMIT;
              flush_src_d = 1'b1;
            end else begin
              state_d = FILL;
            end
          end else if (flush_req) begin
            done_d = 1'b1;
          end
        end
        FILL: begin
          flush_pend_d = 1'b0;
          if (in_q.valid && (in_tag != buf_tag)) begin
            state_d     = EMIT;
            flush_src_d = flush_req;
          end else begin
            if (in_q.valid) begin
              in_take = 1'b1;
              buf_wr  = 1'b1;
            end
            if (line_full_next || flush_req) begin
              state_d     = EMIT;
              flush_src_d = flush_req;
            end
          end
        end
        EMIT, HOLD: begin
          if (flush_in) flush_pend_d = 1'b1;
          if (alfull) begin
            state_d = HOLD;
          end else begin
            do_emit     = 1'b1;
            done_d      = flush_src_q;
            flush_src_d = 1'b0;
            buf_clear   = 1'b1;
            if (in_q.valid) begin
              in_take  = 1'b1;
              buf_wr   = 1'b1;
              buf_open = 1'b1;
              state_d  = FILL;
            end else begin
              state_d = IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    wd0_d = '0;
    wd1_d = '0;
    m0_d  = '0;
    m1_d  = '0;
    if (do_emit) begin
      for (int k = 0; k < HF; k++) begin
        m0_d[HF-1-k] = buf_mask[k];
        m1_d[HF-1-k] = buf_mask[HF+k];
        wd0_d.data[(HF-1-k)*DW +: DW] = buf_mask[k]    ? buf_data[k]    : '0;
        wd1_d.data[(HF-1-k)*DW +: DW] = buf_mask[HF+k] ? buf_data[HF+k] : '0;
      end
      wd0_d.valid                = |m0_d;
      wd1_d.valid                = |m1_d;
      wd0_d.cmd.cu_id_x          = CU_ID_BITS'(CU_ID_X);
      wd0_d.cmd.cu_id_y          = CU_ID_BITS'(CU_ID_Y);
      wd0_d.cmd.address_offset   = {buf_tag, {OB{1'b0}}};
      wd0_d.cmd.cacheline_offset = '0;
      wd1_d.cmd.cu_id_x          = CU_ID_BITS'(CU_ID_X);
      wd1_d.cmd.cu_id_y          = CU_ID_BITS'(CU_ID_Y);
      wd1_d.cmd.address_offset   = {buf_tag, {OB{1'b0}}};
      wd1_d.cmd.cacheline_offset = OB'(HF);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q    <= 1'b0;
      alfull_q     <= 1'b0;
      in_q         <= '0;
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      flush_src_q  <= 1'b0;
      wd0_q        <= '0;
      wd1_q        <= '0;
      m0_q         <= '0;
      m1_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      enabled_q    <= enabled_in;
      alfull_q     <= alfull;
      in_q         <= in_d;
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      flush_src_q  <= flush_src_d;
      wd0_q        <= wd0_d;
      wd1_q        <= wd1_d;
      m0_q         <= m0_d;
      m1_q         <= m1_d;
      done_q       <= done_d;
    end
  end

  assign write_data_0_out = wd0_q;
  assign write_data_1_out = wd1_q;
  assign write_mask_0_out = m0_q;
  assign write_mask_1_out = m1_q;
  assign flush_done_out   = done_q;

endmodule

// File: tb/tb_cu_edge_data_write_pack_control.sv
// Directed bench for the edge-data write pack controller: full line, sparse flush,
// tag mismatch, duplicate overwrite, alfull hold and mid-fill reset.
module tb_cu_edge_data_write_pack_control;
  import CU_PKG::*;

  logic             clock = 1'b0;
  logic             rstn = 1'b0;
  logic             enabled_in = 1'b0;
  logic             flush_in = 1'b0;
  EdgeDataWrite     wr_in;
  BufferStatus      bs;
  logic             ready, done;
  ReadWriteDataLine wd0, wd1;
  logic [15:0]      m0, m1;

  int n_cmp = 0, n_err = 0, emit_cnt = 0, done_cnt = 0;
  ReadWriteDataLine l0, l1;
  logic [15:0]      lm0, lm1;

  always #5 clock = ~clock;

  cu_edge_data_write_pack_control #(.CU_ID_X(1), .CU_ID_Y(1)) dut (
    .clock                     (clock),
    .rstn                      (rstn),
    .enabled_in                (enabled_in),
    .edge_data_write_in        (wr_in),
    .edge_data_write_ready_out (ready),
    .flush_in                  (flush_in),
    .write_buffer_status_in    (bs),
    .write_data_0_out          (wd0),
    .write_data_1_out          (wd1),
    .write_mask_0_out          (m0),
    .write_mask_1_out          (m1),
    .flush_done_out            (done)
  );

  always @(posedge clock) begin
    #2;
    if (wd0.valid || wd1.valid) begin
      emit_cnt++;
      l0  = wd0;
      l1  = wd1;
      lm0 = m0;
      lm1 = m1;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] id, input logic [31:0] data);
    int n = 0;
    @(negedge clock);
    wr_in.valid        = 1'b1;
    wr_in.payload.id   = id;
    wr_in.payload.data = data;
    while (!ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("push_timeout", 1, 0);
    @(posedge clock);
    #1 wr_in.valid = 1'b0;
  endtask

  task automatic wait_emit(input string tag, input int prev);
    int n = 0;
    while (emit_cnt == prev && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_emit_count"}, emit_cnt - prev, 1);
  endtask

  task automatic pulse_flush();
    @(negedge clock);
    flush_in = 1'b1;
    @(negedge clock);
    flush_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] e0, e1;
    int ec, dc;
    wr_in = '0;
    bs    = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ready", ready, 0);
    chk("rst_valids", {wd0.valid, wd1.valid}, 0);
    chk("rst_masks", {m0, m1}, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;
    @(negedge clock);
    enabled_in = 1'b1;
    repeat (2) @(negedge clock);
    chk("en_ready", ready, 1);

    // Full line 64..95
    ec = emit_cnt; dc = done_cnt;
    for (int i = 64; i < 96; i++) push(i, i);
    wait_emit("l64", ec);
    e0 = '0; e1 = '0;
    for (int k = 0; k < 16; k++) begin
      e0[(15-k)*32 +: 32] = 32'(64 + k);
      e1[(15-k)*32 +: 32] = 32'(80 + k);
    end
    chk("l64_valids", {l0.valid, l1.valid}, 2'b11);
    chk("l64_addr0", l0.cmd.address_offset, 64);
    chk("l64_addr1", l1.cmd.address_offset, 64);
    chk("l64_cloff", {l0.cmd.cacheline_offset, l1.cmd.cacheline_offset}, {5'd0, 5'd16});
    chk("l64_cuid", {l0.cmd.cu_id_x, l0.cmd.cu_id_y}, 16'h0101);
    chk("l64_masks", {lm0, lm1}, 32'hFFFF_FFFF);
    chk("l64_data0", l0.data, e0);
    chk("l64_data1", l1.data, e1);
    repeat (3) @(negedge clock);
    chk("l64_no_done", done_cnt - dc, 0);

    // Sparse line with flush: ids 3 and 20
    ec = emit_cnt; dc = done_cnt;
    push(3, 32'h33);
    push(20, 32'h2020);
    pulse_flush();
    wait_emit("sparse", ec);
    e0 = '0; e1 = '0;
    e0[(15-3)*32 +: 32] = 32'h33;
    e1[(15-4)*32 +: 32] = 32'h2020;
    chk("sparse_masks", {lm0, lm1}, {16'h1000, 16'h0800});
    chk("sparse_data0", l0.data, e0);
    chk("sparse_data1", l1.data, e1);
    chk("sparse_addr", l0.cmd.address_offset, 0);
    repeat (3) @(negedge clock);
    chk("sparse_done", done_cnt - dc, 1);

    // Tag mismatch: 5 then 40
    ec = emit_cnt; dc = done_cnt;
    push(5, 32'h55);
    push(40, 32'h4040);
    wait_emit("mism", ec);
    chk("mism_valids", {l0.valid, l1.valid}, 2'b10);
    chk("mism_masks", {lm0, lm1}, {16'h0400, 16'h0000});
    chk("mism_addr", l0.cmd.address_offset, 0);
    ec = emit_cnt;
    repeat (8) @(negedge clock);
    chk("mism_no_early_emit", emit_cnt - ec, 0);
    chk("mism_no_done", done_cnt - dc, 0);
    pulse_flush();
    wait_emit("line32", ec);
    e0 = '0;
    e0[(15-8)*32 +: 32] = 32'h4040;
    chk("line32_valids", {l0.valid, l1.valid}, 2'b10);
    chk("line32_addr", l0.cmd.address_offset, 32);
    chk("line32_masks", {lm0, lm1}, {16'h0080, 16'h0000});
    chk("line32_data0", l0.data, e0);
    repeat (3) @(negedge clock);
    chk("line32_done", done_cnt - dc, 1);

    // Duplicate offset: last writer wins
    ec = emit_cnt;
    push(7, 32'hA);
    push(7, 32'hB);
    pulse_flush();
    wait_emit("dup", ec);
    e0 = '0;
    e0[(15-7)*32 +: 32] = 32'hB;
    chk("dup_masks", {lm0, lm1}, {16'h0100, 16'h0000});
    chk("dup_data0", l0.data, e0);
    repeat (3) @(negedge clock);

    // alfull holds a completed line
    ec = emit_cnt;
    for (int i = 128; i < 159; i++) push(i, i);
    @(negedge clock);
    chk("af_pre_ready", ready, 1);
    wr_in.valid        = 1'b1;
    wr_in.payload.id   = 159;
    wr_in.payload.data = 159;
    bs.alfull          = 1'b1;
    @(posedge clock);
    #1 wr_in.valid = 1'b0;
    @(negedge clock);
    chk("af_ready_low", ready, 0);
    repeat (6) @(negedge clock);
    chk("af_hold_no_emit", emit_cnt - ec, 0);
    bs.alfull = 1'b0;
    @(negedge clock);
    chk("af_release_emit", emit_cnt - ec, 1);
    e0 = '0; e1 = '0;
    for (int k = 0; k < 16; k++) begin
      e0[(15-k)*32 +: 32] = 32'(128 + k);
      e1[(15-k)*32 +: 32] = 32'(144 + k);
    end
    chk("af_addr", l1.cmd.address_offset, 128);
    chk("af_masks", {lm0, lm1}, 32'hFFFF_FFFF);
    chk("af_data0", l0.data, e0);
    chk("af_data1", l1.data, e1);
    repeat (3) @(negedge clock);

    // Reset with 10 buffered elements
    ec = emit_cnt;
    for (int i = 200; i < 210; i++) push(i, i);
    repeat (2) @(negedge clock);
    rstn = 1'b0;
    repeat (2) @(negedge clock);
    rstn = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst_mid_no_emit", emit_cnt - ec, 0);
    dc = done_cnt;
    pulse_flush();
    repeat (4) @(negedge clock);
    chk("rst_mid_flush_no_emit", emit_cnt - ec, 0);
    chk("rst_mid_flush_done", done_cnt - dc, 1);

    // Disable drops ready
    enabled_in = 1'b0;
    repeat (2) @(negedge clock);
    chk("dis_ready", ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
